// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way branch target buffer.
package btb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        case (cnt)
            CNT_SNT: r = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: r = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  r = taken ? CNT_ST  : CNT_WNT;
            default: r = taken ? CNT_ST  : CNT_WT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/target/counter arrays with two combinational read
// ports (fetch lookup, execute update) and one synchronous write port.
module btb_way #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 6,
    parameter int TGT_W   = 14
) (
    input  logic               clk,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [TGT_W-1:0]   rd_tgt_o,
    output logic [1:0]         rd_cnt_o,
    input  logic [INDEX_W-1:0] up_idx_i,
    output logic               up_valid_o,
    output logic [TAG_W-1:0]   up_tag_o,
    output logic [TGT_W-1:0]   up_tgt_o,
    output logic [1:0]         up_cnt_o,
    input  logic               inv_en_i,
    input  logic [INDEX_W-1:0] inv_idx_i,
    input  logic               wr_en_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [TGT_W-1:0]   wr_tgt_i,
    input  logic [1:0]         wr_cnt_i
);
    localparam int SETS = 1 << INDEX_W;

    logic               valid_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS];
    logic [TGT_W-1:0]   tgt_q   [SETS];
    logic [1:0]         cnt_q   [SETS];

    // Valid bits are cleared by the sweep; payload arrays carry no reset.
    always_ff @(posedge clk) begin
        if (inv_en_i) begin
            valid_q[inv_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            valid_q[up_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[up_idx_i] <= wr_tag_i;
            tgt_q[up_idx_i] <= wr_tgt_i;
            cnt_q[up_idx_i] <= wr_cnt_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_tgt_o   = tgt_q[rd_idx_i];
    assign rd_cnt_o   = cnt_q[rd_idx_i];

    assign up_valid_o = valid_q[up_idx_i];
    assign up_tag_o   = tag_q[up_idx_i];
    assign up_tgt_o   = tgt_q[up_idx_i];
    assign up_cnt_o   = cnt_q[up_idx_i];

endmodule

// File: rtl/btb_2way_predictor.sv
// 2-way set-associative BTB with 2-bit direction counters, per-set LRU and a
// post-reset invalidation sweep.
//   state | meaning
//   INIT  | sweeping sets, clearing valid and lru; lookups miss, updates dropped
//   RUN   | normal lookup and training
module btb_2way_predictor
    import btb_pkg::*;
#(
    parameter int         ADDR_W   = 16,
    parameter int         INDEX_W  = 8,
    parameter logic [1:0] CNT_INIT = CNT_WT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc_predict,
    output logic              hit,
    output logic              pred_taken,
    input  logic              we,
    input  logic [ADDR_W-1:0] pc_actual,
    input  logic [ADDR_W-1:0] npc_actual,
    input  logic              taken_actual,
    output logic              busy
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int TGT_W = ADDR_W - 2;
    localparam int SETS  = 1 << INDEX_W;

    state_e             state_q;
    logic [INDEX_W-1:0] sweep_q;
    logic               lru_q [SETS];
    logic               lru_d;

    logic               run;
    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;

    logic               rd_v [2];
    logic [TAG_W-1:0]   rd_t [2];
    logic [TGT_W-1:0]   rd_g [2];
    logic [1:0]         rd_c [2];
    logic               up_v [2];
    logic [TAG_W-1:0]   up_t [2];
    logic [TGT_W-1:0]   up_g [2];
    logic [1:0]         up_c [2];

    logic               lk_m0, lk_m1;
    logic [1:0]         lk_cnt;
    logic [TGT_W-1:0]   lk_tgt;
    logic               up_m0, up_m1, up_hit;
    logic               victim, wsel, do_upd;
    logic [1:0]         cur_cnt, wr_cnt;
    logic [TGT_W-1:0]   cur_tgt, wr_tgt;
    logic [1:0]         wr_en;
    logic               unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    sweep_q <= sweep_q + INDEX_W'(1);
                    if (sweep_q == '1) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign run  = (state_q == RUN);
    assign busy = (state_q == INIT);

    assign lk_idx = pc[INDEX_W+1:2];
    assign lk_tag = pc[ADDR_W-1:INDEX_W+2];
    assign up_idx = pc_actual[INDEX_W+1:2];
    assign up_tag = pc_actual[ADDR_W-1:INDEX_W+2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W),
            .TGT_W   (TGT_W)
        ) u_way (
            .clk        (clk),
            .rd_idx_i   (lk_idx),
            .rd_valid_o (rd_v[w]),
            .rd_tag_o   (rd_t[w]),
            .rd_tgt_o   (rd_g[w]),
            .rd_cnt_o   (rd_c[w]),
            .up_idx_i   (up_idx),
            .up_valid_o (up_v[w]),
            .up_tag_o   (up_t[w]),
            .up_tgt_o   (up_g[w]),
            .up_cnt_o   (up_c[w]),
            .inv_en_i   (busy),
            .inv_idx_i  (sweep_q),
            .wr_en_i    (wr_en[w]),
            .wr_tag_i   (up_tag),
            .wr_tgt_i   (wr_tgt),
            .wr_cnt_i   (wr_cnt)
        );
    end

    // Fetch-side lookup; way0 wins if both ways ever match.
    always_comb begin
        lk_m0       = run && rd_v[0] && (rd_t[0] == lk_tag);
        lk_m1       = run && rd_v[1] && (rd_t[1] == lk_tag);
        lk_cnt      = lk_m0 ? rd_c[0] : rd_c[1];
        lk_tgt      = lk_m0 ? rd_g[0] : rd_g[1];
        hit         = lk_m0 || lk_m1;
        pred_taken  = hit && lk_cnt[1];
        npc_predict = pred_taken ? {lk_tgt, 2'b00} : pc + ADDR_W'(4);
    end

    // Execute-side training: hit way, else first invalid way, else LRU way.
    always_comb begin
        up_m0   = up_v[0] && (up_t[0] == up_tag);
        up_m1   = up_v[1] && (up_t[1] == up_tag);
        up_hit  = up_m0 || up_m1;
        victim  = !up_v[0] ? 1'b0 : (!up_v[1] ? 1'b1 : lru_q[up_idx]);
        wsel    = up_hit ? !up_m0 : victim;
        do_upd  = run && we && (up_hit || taken_actual);
        cur_cnt = up_m0 ? up_c[0] : up_c[1];
        cur_tgt = up_m0 ? up_g[0] : up_g[1];
        wr_cnt  = up_hit ? cnt_next(cur_cnt, taken_actual) : CNT_INIT;
        wr_tgt  = (up_hit && !taken_actual) ? cur_tgt : npc_actual[ADDR_W-1:2];
        wr_en   = {do_upd && wsel, do_upd && !wsel};
        lru_d   = !wsel;
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            lru_q[sweep_q] <= 1'b0;
        end else if (do_upd) begin
            lru_q[up_idx] <= lru_d;
        end
    end

    assign unused_bits = ^{pc[1:0], pc_actual[1:0], npc_actual[1:0]};

endmodule

// File: tb/tb_btb_2way_predictor.sv
// Self-checking bench for btb_2way_predictor: reset sweep, directed table,
// and randomized traffic against a set/way array reference model.
module tb_btb_2way_predictor;

    logic        clk = 1'b0;
    logic        rst, we, taken_actual;
    logic [15:0] pc, pc_actual, npc_actual;
    logic [15:0] npc_predict;
    logic        hit, pred_taken, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btb_2way_predictor #(.ADDR_W(16), .INDEX_W(8), .CNT_INIT(2'b10)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .npc_predict  (npc_predict),
        .hit          (hit),
        .pred_taken   (pred_taken),
        .we           (we),
        .pc_actual    (pc_actual),
        .npc_actual   (npc_actual),
        .taken_actual (taken_actual),
        .busy         (busy)
    );

    // Reference model: plain arrays per way and set, cycles of sweep left.
    bit mv   [2][256];
    int mtag [2][256];
    int mtgt [2][256];
    int mcnt [2][256];
    int mlru [256];
    int mb;

    logic        obs_busy, obs_hit, obs_pred;
    logic [15:0] obs_npc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_lookup(input int p, output int h, output int pt, output int np);
        int idx, tg;
        idx = (p >> 2) & 255;
        tg  = p >> 10;
        h = 0; pt = 0; np = (p + 4) & 16'hFFFF;
        if (mb == 0) begin
            for (int w = 0; w < 2; w++) begin
                if (h == 0 && mv[w][idx] && mtag[w][idx] == tg) begin
                    h  = 1;
                    pt = (mcnt[w][idx] >= 2) ? 1 : 0;
                    if (pt != 0) np = mtgt[w][idx];
                end
            end
        end
    endfunction

    function automatic void m_clock(input bit r, input bit w, input int pa, input int na, input bit t);
        int idx, tg, hw, v;
        if (r) begin
            mb = 256;
            for (int s = 0; s < 256; s++) begin
                mv[0][s] = 0; mv[1][s] = 0; mlru[s] = 0;
            end
        end else if (mb > 0) begin
            mb--;
        end else if (w) begin
            idx = (pa >> 2) & 255;
            tg  = pa >> 10;
            hw  = -1;
            if (mv[0][idx] && mtag[0][idx] == tg) hw = 0;
            else if (mv[1][idx] && mtag[1][idx] == tg) hw = 1;
            if (hw >= 0) begin
                if (t) begin
                    if (mcnt[hw][idx] < 3) mcnt[hw][idx]++;
                    mtgt[hw][idx] = na & 16'hFFFC;
                end else if (mcnt[hw][idx] > 0) begin
                    mcnt[hw][idx]--;
                end
                mlru[idx] = 1 - hw;
            end else if (t) begin
                v = !mv[0][idx] ? 0 : (!mv[1][idx] ? 1 : mlru[idx]);
                mv[v][idx]   = 1;
                mtag[v][idx] = tg;
                mtgt[v][idx] = na & 16'hFFFC;
                mcnt[v][idx] = 2;
                mlru[idx]    = 1 - v;
            end
        end
    endfunction

    task automatic cyc(input bit r, input bit w, input logic [15:0] p,
                       input logic [15:0] pa, input logic [15:0] na, input bit t);
        int eh, ept, enp;
        rst = r; we = w; pc = p; pc_actual = pa; npc_actual = na; taken_actual = t;
        @(negedge clk);
        m_lookup(int'(p), eh, ept, enp);
        obs_busy = busy; obs_hit = hit; obs_pred = pred_taken; obs_npc = npc_predict;
        chk("model_busy", 32'(busy), 32'(mb > 0));
        chk("model_hit", 32'(hit), 32'(eh));
        chk("model_pred", 32'(pred_taken), 32'(ept));
        chk("model_npc", 32'(npc_predict), 32'(enp));
        @(posedge clk);
        m_clock(r, w, int'(pa), int'(na), t);
        #1;
    endtask

    // Counts busy cycles following a reset; bounded so a stuck sweep fails.
    task automatic count_sweep(input bit probe_we, output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, probe_we && (i == 10), 16'h0100, 16'h0100, 16'h0300, 1'b1);
            if (!obs_busy) break;
            chk("sweep_npc", 32'(obs_npc), 32'h0104);
            n++;
        end
    endtask

    typedef struct {
        bit          we;
        logic [15:0] pc;
        logic [15:0] pa;
        logic [15:0] na;
        bit          tk;
        bit          eh;
        bit          ep;
        logic [15:0] en;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        logic [15:0] sets [4];
        logic [5:0]  tags [4];
        logic [15:0] p, pa;

        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 1, 0, 0, 16'h0044});
        tbl.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 0, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 0, 1, 1, 16'h0200});
        tbl.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 0, 1, 0, 16'h0044});
        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 1, 1, 0, 16'h0044});
        tbl.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 0, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 1, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 1, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 1, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0040, 16'h0040, 16'h0200, 0, 1, 1, 16'h0200});
        tbl.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 0, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0440, 16'h0440, 16'h0600, 1, 0, 0, 16'h0444});
        tbl.push_back('{0, 16'h0440, 16'h0000, 16'h0000, 0, 1, 1, 16'h0600});
        tbl.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 0, 1, 1, 16'h0200});
        tbl.push_back('{1, 16'h0440, 16'h0040, 16'h0200, 1, 1, 1, 16'h0600});
        tbl.push_back('{1, 16'h0840, 16'h0840, 16'h0A00, 1, 0, 0, 16'h0844});
        tbl.push_back('{0, 16'h0440, 16'h0000, 16'h0000, 0, 0, 0, 16'h0444});
        tbl.push_back('{0, 16'h0040, 16'h0000, 16'h0000, 0, 1, 1, 16'h0200});
        tbl.push_back('{0, 16'h0840, 16'h0000, 16'h0000, 0, 1, 1, 16'h0A00});
        tbl.push_back('{1, 16'h1000, 16'h1000, 16'h2000, 0, 0, 0, 16'h1004});
        tbl.push_back('{0, 16'h1000, 16'h0000, 16'h0000, 0, 0, 0, 16'h1004});
        tbl.push_back('{0, 16'hFFFC, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000});
        tbl.push_back('{1, 16'hFFFC, 16'hFFFC, 16'h0010, 1, 0, 0, 16'h0000});
        tbl.push_back('{0, 16'hFFFC, 16'h0000, 16'h0000, 0, 1, 1, 16'h0010});

        rst = 1'b1; we = 1'b0; pc = '0; pc_actual = '0; npc_actual = '0; taken_actual = 1'b0;
        @(posedge clk);
        m_clock(1'b1, 1'b0, 0, 0, 1'b0);
        #1;

        // Sweep length, with an update issued mid-sweep that must be dropped.
        count_sweep(1'b1, n);
        chk("sweep_len", 32'(n), 32'd256);
        chk("sweep_we_dropped", 32'(obs_hit), 32'd0);
        chk("post_sweep_npc", 32'(obs_npc), 32'h0104);

        // Reset asserted again partway through a sweep restarts it fully.
        cyc(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        chk("mid_sweep_busy", 32'(obs_busy), 32'd1);
        cyc(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        count_sweep(1'b0, n);
        chk("restart_sweep_len", 32'(n), 32'd256);

        foreach (tbl[i]) begin
            cyc(1'b0, tbl[i].we, tbl[i].pc, tbl[i].pa, tbl[i].na, tbl[i].tk);
            chk($sformatf("tbl%0d_hit", i), 32'(obs_hit), 32'(tbl[i].eh));
            chk($sformatf("tbl%0d_pred", i), 32'(obs_pred), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d_npc", i), 32'(obs_npc), 32'(tbl[i].en));
        end

        // Random traffic over a few sets and tags to force sharing and eviction.
        sets[0] = 16'h0010; sets[1] = 16'h0011; sets[2] = 16'h00FF; sets[3] = 16'h0000;
        tags[0] = 6'h00; tags[1] = 6'h01; tags[2] = 6'h02; tags[3] = 6'h3F;
        for (int i = 0; i < 3000; i++) begin
            p  = {tags[$urandom_range(0, 3)], sets[$urandom_range(0, 3)][7:0], 2'b00};
            pa = {tags[$urandom_range(0, 3)], sets[$urandom_range(0, 3)][7:0], 2'(($urandom_range(0, 3)))};
            cyc($urandom_range(0, 999) == 0, 1'($urandom_range(0, 1)), p, pa,
                16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
